// File: rtl/wb_regfile.sv
// Write-back register file: two combinational read ports, one write port, dirty bitmap and write counter.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to matching read ports.
module wb_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                re1,
    input  logic [ADDR_W-1:0]   raddr1,
    output logic [DATA_W-1:0]   rdata1,
    input  logic                re2,
    input  logic [ADDR_W-1:0]   raddr2,
    output logic [DATA_W-1:0]   rdata2,
    input  logic                dirty_clr,
    output logic [NUM_REGS-1:0] dirty,
    output logic [31:0]         wr_count
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] dirty_q;
    logic [31:0]         wr_count_q;
    logic                wr_ok;

    // r0 is hardwired to zero, so writes to it are neither stored nor counted.
    assign wr_ok = !rst && we && (waddr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            dirty_q    <= '0;
            wr_count_q <= '0;
        end else begin
            if (dirty_clr) begin
                dirty_q <= '0;
            end
            // Placed after the clear so a colliding write keeps its own bit set.
            if (wr_ok) begin
                regs[waddr]    <= wdata;
                dirty_q[waddr] <= 1'b1;
                wr_count_q     <= wr_count_q + 32'd1;
            end
        end
    end

    always_comb begin
        rdata1 = '0;
        if (!rst && re1 && (raddr1 != '0)) begin
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && (raddr1 == waddr)) begin
                rdata1 = wdata;
            end else begin
                rdata1 = regs[raddr1];
            end
`else
            rdata1 = regs[raddr1];
`endif
        end
    end

    always_comb begin
        rdata2 = '0;
        if (!rst && re2 && (raddr2 != '0)) begin
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && (raddr2 == waddr)) begin
                rdata2 = wdata;
            end else begin
                rdata2 = regs[raddr2];
            end
`else
            rdata2 = regs[raddr2];
`endif
        end
    end

    assign dirty    = dirty_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile; expected values are hand-computed constants.
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic        dirty_clr;
    logic [31:0] dirty;
    logic [31:0] wr_count;

    int checks;
    int errors;

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
        .dirty_clr(dirty_clr), .dirty(dirty), .wr_count(wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1; waddr = a; wdata = d;
        @(posedge clk); #1;
        we = 1'b0;
    endtask

    task automatic set_reads(input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2);
        re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
        #1;
    endtask

    task automatic test_reset();
        do_write(5'd5, 32'hDEADBEEF);
        @(negedge clk);
        rst = 1'b1;
        set_reads(1'b1, 5'd5, 1'b1, 5'd5);
        checks++;
        if (rdata1 !== 32'h0) begin errors++; $display("FAIL rst_rdata1 got %h exp %h", rdata1, 32'h0); end
        checks++;
        if (rdata2 !== 32'h0) begin errors++; $display("FAIL rst_rdata2 got %h exp %h", rdata2, 32'h0); end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if (rdata1 !== 32'h0) begin errors++; $display("FAIL reset_r5 got %h exp %h", rdata1, 32'h0); end
        checks++;
        if (dirty !== 32'h0) begin errors++; $display("FAIL reset_dirty got %h exp %h", dirty, 32'h0); end
        checks++;
        if (wr_count !== 32'd0) begin errors++; $display("FAIL reset_count got %0d exp %0d", wr_count, 0); end
    endtask

    task automatic test_r0();
        do_write(5'd0, 32'h12345678);
        set_reads(1'b1, 5'd0, 1'b0, 5'd0);
        checks++;
        if (rdata1 !== 32'h0) begin errors++; $display("FAIL r0_read got %h exp %h", rdata1, 32'h0); end
        checks++;
        if (dirty[0] !== 1'b0) begin errors++; $display("FAIL r0_dirty got %b exp %b", dirty[0], 1'b0); end
        checks++;
        if (wr_count !== 32'd0) begin errors++; $display("FAIL r0_count got %0d exp %0d", wr_count, 0); end
    endtask

    task automatic test_basic();
        do_write(5'd3, 32'h0000FFFF);
        do_write(5'd31, 32'hA5A5A5A5);
        set_reads(1'b1, 5'd3, 1'b1, 5'd31);
        checks++;
        if (rdata1 !== 32'h0000FFFF) begin errors++; $display("FAIL basic_r3 got %h exp %h", rdata1, 32'h0000FFFF); end
        checks++;
        if (rdata2 !== 32'hA5A5A5A5) begin errors++; $display("FAIL basic_r31 got %h exp %h", rdata2, 32'hA5A5A5A5); end
        checks++;
        if (dirty !== 32'h80000008) begin errors++; $display("FAIL basic_dirty got %h exp %h", dirty, 32'h80000008); end
        checks++;
        if (wr_count !== 32'd2) begin errors++; $display("FAIL basic_count got %0d exp %0d", wr_count, 2); end
        set_reads(1'b1, 5'd31, 1'b1, 5'd3);
        checks++;
        if (rdata1 !== 32'hA5A5A5A5) begin errors++; $display("FAIL swap_r31 got %h exp %h", rdata1, 32'hA5A5A5A5); end
        checks++;
        if (rdata2 !== 32'h0000FFFF) begin errors++; $display("FAIL swap_r3 got %h exp %h", rdata2, 32'h0000FFFF); end
        set_reads(1'b0, 5'd3, 1'b0, 5'd31);
        checks++;
        if (rdata1 !== 32'h0) begin errors++; $display("FAIL re1_off got %h exp %h", rdata1, 32'h0); end
        checks++;
        if (rdata2 !== 32'h0) begin errors++; $display("FAIL re2_off got %h exp %h", rdata2, 32'h0); end
    endtask

    task automatic test_same_cycle();
        logic [31:0] exp_now;
        do_write(5'd7, 32'h11111111);
        @(negedge clk);
        we = 1'b1; waddr = 5'd7; wdata = 32'h22222222;
        set_reads(1'b1, 5'd7, 1'b1, 5'd7);
`ifdef REGFILE_BYPASS_EN
        exp_now = 32'h22222222;
`else
        exp_now = 32'h11111111;
`endif
        checks++;
        if (rdata1 !== exp_now) begin errors++; $display("FAIL same_cyc_p1 got %h exp %h", rdata1, exp_now); end
        checks++;
        if (rdata2 !== exp_now) begin errors++; $display("FAIL same_cyc_p2 got %h exp %h", rdata2, exp_now); end
        @(posedge clk); #1;
        we = 1'b0;
        #1;
        checks++;
        if (rdata1 !== 32'h22222222) begin errors++; $display("FAIL next_cyc_p1 got %h exp %h", rdata1, 32'h22222222); end
        checks++;
        if (rdata2 !== 32'h22222222) begin errors++; $display("FAIL next_cyc_p2 got %h exp %h", rdata2, 32'h22222222); end
        checks++;
        if (wr_count !== 32'd4) begin errors++; $display("FAIL same_cyc_count got %0d exp %0d", wr_count, 4); end
    endtask

    task automatic test_dirty_clr();
        @(negedge clk);
        dirty_clr = 1'b1;
        @(posedge clk); #1;
        dirty_clr = 1'b0;
        checks++;
        if (dirty !== 32'h0) begin errors++; $display("FAIL clr_only got %h exp %h", dirty, 32'h0); end
        do_write(5'd1, 32'h00000001);
        do_write(5'd2, 32'h00000002);
        checks++;
        if (dirty !== 32'h00000006) begin errors++; $display("FAIL dirty_pre got %h exp %h", dirty, 32'h00000006); end
        @(negedge clk);
        dirty_clr = 1'b1; we = 1'b1; waddr = 5'd9; wdata = 32'h99990009;
        @(posedge clk); #1;
        dirty_clr = 1'b0; we = 1'b0;
        set_reads(1'b1, 5'd9, 1'b1, 5'd3);
        checks++;
        if (dirty !== 32'h00000200) begin errors++; $display("FAIL clr_collide got %h exp %h", dirty, 32'h00000200); end
        checks++;
        if (rdata1 !== 32'h99990009) begin errors++; $display("FAIL clr_r9 got %h exp %h", rdata1, 32'h99990009); end
        checks++;
        if (rdata2 !== 32'h0000FFFF) begin errors++; $display("FAIL clr_keeps_r3 got %h exp %h", rdata2, 32'h0000FFFF); end
        checks++;
        if (wr_count !== 32'd7) begin errors++; $display("FAIL clr_count got %0d exp %0d", wr_count, 7); end
    endtask

    task automatic test_wrap_and_reset_write();
        @(negedge clk);
        dut.wr_count_q = 32'hFFFFFFFF;
        #1;
        checks++;
        if (wr_count !== 32'hFFFFFFFF) begin errors++; $display("FAIL preload got %h exp %h", wr_count, 32'hFFFFFFFF); end
        do_write(5'd10, 32'h0A0A0A0A);
        checks++;
        if (wr_count !== 32'd0) begin errors++; $display("FAIL wrap got %h exp %h", wr_count, 32'h0); end
        @(negedge clk);
        rst = 1'b1; we = 1'b1; waddr = 5'd12; wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        rst = 1'b0; we = 1'b0;
        set_reads(1'b1, 5'd12, 1'b1, 5'd10);
        checks++;
        if (rdata1 !== 32'h0) begin errors++; $display("FAIL rst_drop_r12 got %h exp %h", rdata1, 32'h0); end
        checks++;
        if (rdata2 !== 32'h0) begin errors++; $display("FAIL rst_clears_r10 got %h exp %h", rdata2, 32'h0); end
        checks++;
        if (wr_count !== 32'd0) begin errors++; $display("FAIL rst_drop_count got %0d exp %0d", wr_count, 0); end
        checks++;
        if (dirty !== 32'h0) begin errors++; $display("FAIL rst_drop_dirty got %h exp %h", dirty, 32'h0); end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0; dirty_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_r0();
        test_basic();
        test_same_cycle();
        test_dirty_clr();
        test_wrap_and_reset_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- General-purpose register file for the 5-stage pipeline.
- It is the receiving end of the write-back path. It accepts the WB-stage write triple (address, enable, data) and serves the two combinational operand reads needed by ID.
- It also keeps a per-register written-since-clear bitmap and a retired-write counter, used for debug and verification visibility.

Parameters:
- DATA_W, 32, register and data width (RegBus).
- ADDR_W, 5, register address width (RegAddrBus).
- NUM_REGS, 32, number of registers; must equal 2**ADDR_W.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous active-high reset.
- we  input  1  write enable, driven by WB-stage wb_wreg.
- waddr  input  ADDR_W  write register address, driven by wb_wd.
- wdata  input  DATA_W  write data, driven by wb_wdata.
- re1  input  1  read port 1 enable.
- raddr1  input  ADDR_W  read port 1 address.
- rdata1  output  DATA_W  read port 1 data, combinational.
- re2  input  1  read port 2 enable.
- raddr2  input  ADDR_W  read port 2 address.
- rdata2  output  DATA_W  read port 2 data, combinational.
- dirty_clr  input  1  clear the dirty bitmap.
- dirty  output  NUM_REGS  bit i = register i written since last reset/clear.
- wr_count  output  32  count of accepted writes.

Behaviour:

Reset
- Reset is rst, synchronous, active-high, on clock clk.
- At a clk edge with rst=1: all NUM_REGS entries become 0, dirty becomes 0, wr_count becomes 0.
- Any write presented in that same cycle is dropped.
- While rst=1, rdata1 and rdata2 are forced to 0.

Write
- A write is accepted at a clk edge when rst=0, we=1 and waddr!=0.
- Accepted write: reg[waddr] <= wdata; dirty[waddr] <= 1; wr_count <= wr_count+1.
- Write latency is 1 cycle: the value is visible from the array on the following cycle.
- Writes to r0 are discarded: not stored, not counted, and dirty[0] stays 0 permanently.
- wr_count wraps from 0xFFFFFFFF to 0 with no flag.

Read
- Reads are purely combinational; no clock involved.
- Each read port resolves in this priority order:
  1. rst=1 -> 0.
  2. re=0 -> 0.
  3. raddr=0 -> 0.
  4. Bypass hit (only when the optional feature is compiled in) -> wdata.
  5. Otherwise -> reg[raddr].
- Both ports may read the same address, including the address being written, in the same cycle.

Dirty bitmap
- dirty_clr=1 at an edge clears all bits.
- If dirty_clr and an accepted write occur in the same edge, the result is only bit waddr set. The write takes priority over the clear for that bit.
- dirty_clr does not affect wr_count or register contents.

Other
- The block has no backpressure: every qualifying write is accepted in its cycle.
- The array stays 32x32 flops so that it can be reset; it is not inferred as RAM.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: same-cycle write-to-read bypass is active. When rst=0, we=1, waddr!=0, re=1 and raddr==waddr, that port returns wdata, not the stale array value. This resolves the WB-to-ID hazard that exists because the regfile is written at the end of WB.
- Undefined: no bypass; the port returns the old reg[raddr]. The pipeline must then cover that hazard by other means.
- All other behaviour is identical in both builds.

Test Plan:
1. Reset clears state:
   - Stimulus: write 0xDEADBEEF to r5, then assert rst for 1 cycle.
   - Response: reading r5 returns 0; dirty=0; wr_count=0. While rst=1, both rdata ports read 0 even with re=1.
2. Writes to r0 ignored:
   - Stimulus: write 0x12345678 to r0 with we=1.
   - Response: next cycle raddr1=0, re1=1 gives rdata1=0; dirty[0]=0; wr_count unchanged.
3. Basic write/read and counting:
   - Stimulus: write 0x0000FFFF to r3, then 0xA5A5A5A5 to r31.
   - Response: next cycle port1(r3)=0x0000FFFF and port2(r31)=0xA5A5A5A5; dirty=0x80000008; wr_count=2. The same reads with re=0 return 0.
4. Same-cycle read of the address being written:
   - Stimulus: r7 holds 0x11111111; in one cycle write 0x22222222 to r7 while reading r7 on both ports.
   - Response: with REGFILE_BYPASS_EN, both ports read 0x22222222 that cycle. Without it, both read 0x11111111. In both builds both ports read 0x22222222 the next cycle.
5. Dirty clear colliding with a write:
   - Stimulus: dirty=0x00000006; assert dirty_clr in the same cycle as a write to r9.
   - Response: dirty=0x00000200; r9 updated; wr_count incremented by 1.
6. Counter wrap and reset mid-write:
   - Stimulus: force wr_count to 0xFFFFFFFF via 2^32-1 writes (or a bench backdoor), then one more write.
   - Response: wr_count=0. A write presented in the same cycle as rst=1 leaves the target register at 0 after reset.
